// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined adder/subtractor built from a chain of 4-bit
// carry-lookahead slices, one slice per pipeline stage.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The whole pipe moves as one unit: adv = out_ready | ~out_valid.
// in_ready is adv. Every register, including the valid bits, loads only when
// adv = 1. Bubbles are not squeezed out while the pipe is stalled.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake
//   a, b               operands (WIDTH bits)
//   cin                carry-in (add) / active-high borrow-in (subtract)
//   sub                0 = add, 1 = subtract
//   out_valid/out_ready output handshake
//   sum                result (WIDTH bits)
//   cout               carry-out (add) / active-high borrow-out (subtract)
//   ovf                signed two's-complement overflow
//   zero               sum == 0
//
// Stage 0 registers the operands with b and cin pre-inverted for subtract.
// Stage k (1..NSLICE) adds bits [4k-1:4k-4] using the carry from stage k-1.
// The flags are computed from the last slice and registered beside the sum.
// Latency is NSLICE+1 edges from accept to visible result.
module cla_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_width_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 in 4..64");
  end

  // Returns {carry out of bit 3, carry into bit 3, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Per-stage registers; index k is the output of stage k.
  logic             v_q   [NSLICE+1];
  logic [WIDTH-1:0] a_q   [NSLICE+1];
  logic [WIDTH-1:0] b_q   [NSLICE+1];
  logic [WIDTH-1:0] s_q   [NSLICE+1];
  logic             c_q   [NSLICE+1];
  logic             sub_q [NSLICE+1];

  logic cout_q;
  logic ovf_q;
  logic zero_q;

  // Combinational slice results feeding stage k; index 0 is unused.
  logic [3:0]       slice_sum  [NSLICE+1];
  logic             slice_co   [NSLICE+1];
  logic             slice_cmsb [NSLICE+1];
  logic [WIDTH-1:0] s_next     [NSLICE+1];

  always_comb begin
    for (int k = 0; k <= NSLICE; k++) begin
      slice_sum[k]  = '0;
      slice_co[k]   = 1'b0;
      slice_cmsb[k] = 1'b0;
      s_next[k]     = '0;
    end
    for (int k = 1; k <= NSLICE; k++) begin
      {slice_co[k], slice_cmsb[k], slice_sum[k]} =
        cla4(a_q[k-1][4*k-4 +: 4], b_q[k-1][4*k-4 +: 4], c_q[k-1]);
      s_next[k]               = s_q[k-1];
      s_next[k][4*k-4 +: 4]   = slice_sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NSLICE; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      // Stage 0: with adv = 1, in_ready = 1, so in_valid alone means accept.
      v_q[0]   <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= sub ? ~b : b;
      c_q[0]   <= sub ? ~cin : cin;
      sub_q[0] <= sub;
      s_q[0]   <= '0;
      for (int k = 1; k <= NSLICE; k++) begin
        v_q[k]   <= v_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_next[k];
        c_q[k]   <= slice_co[k];
        sub_q[k] <= sub_q[k-1];
      end
      // Subtraction is a + ~b + ~borrow, so borrow-out is the inverted carry.
      cout_q <= slice_co[NSLICE] ^ sub_q[NSLICE-1];
      ovf_q  <= slice_co[NSLICE] ^ slice_cmsb[NSLICE];
      zero_q <= (s_next[NSLICE] == '0);
    end
  end

  assign out_valid = v_q[NSLICE];
  assign sum       = s_q[NSLICE];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Testbench for cla_pipe_addsub (WIDTH=16): directed vector table with
// hand-computed results, plus latency, stall and mid-stream reset sequences.
module tb_cla_pipe_addsub;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  cla_pipe_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q [$];
  logic [W+2:0] cur_exp;
  logic [W+2:0] head;
  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  bit           consec   = 0;
  bit           have_last = 0;
  int           last_cyc = 0;
  bit           saw_valid = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: transfers are sampled on the falling edge, half a cycle before
  // the rising edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) saw_valid = 1;
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {13'd0, sum, cout, ovf, zero}, 32'd0);
        end else begin
          head = exp_q.pop_front();
          check("result", {13'd0, sum, cout, ovf, zero}, {13'd0, head});
          if (consec) begin
            if (have_last) check("consecutive", cyc - last_cyc, 1);
            have_last = 1;
            last_cyc  = cyc;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int idx);
    a        = vecs[idx].a;
    b        = vecs[idx].b;
    cin      = vecs[idx].cin;
    sub      = vecs[idx].sub;
    cur_exp  = {vecs[idx].sum, vecs[idx].cout, vecs[idx].ovf, vecs[idx].zero};
    in_valid = 1'b1;
  endtask

  task automatic send(input int idx);
    int guard;
    guard = 0;
    load(idx);
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h1000, 16'h0FFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_sum", sum, 0);
    check("reset_flags", {cout, ovf, zero}, 0);

    // Single transaction latency: visible after 5 edges counting the accept edge.
    out_ready = 1'b1;
    load(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_edges", n, 5);
    drain();

    // Back-to-back mixed add/sub stream, one result per cycle.
    consec = 1; have_last = 0;
    for (int i = 0; i < NVEC; i++) send(i);
    drain();
    consec = 0;

    // Stall with a full pipeline: five in flight, output held for 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i + 4);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold", {13'd0, sum, cout, ovf, zero}, {13'd0, exp_q[0]});
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three transactions in flight: nothing may come out afterwards.
    send(0); send(1); send(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_outputs", {13'd0, sum, cout, ovf, zero}, 0);
    saw_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", saw_valid, 0);
    send(9);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
